// File: rtl/tank_move_ctrl_if.sv
// Bundle between the button/event source and the tank movement controller.
// The master drives buttons and events; the slave returns the tank pose to the pixel stage.
interface tank_move_if;
    logic       enable;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       hit;
    logic       respawn;
    logic [4:0] x_rel_pos;
    logic [4:0] y_rel_pos;
    logic [1:0] tank_dir;
    logic       tank_state;
    logic       moved;

    modport master (
        output enable, btn_up, btn_down, btn_left, btn_right, hit, respawn,
        input  x_rel_pos, y_rel_pos, tank_dir, tank_state, moved
    );

    modport slave (
        input  enable, btn_up, btn_down, btn_left, btn_right, hit, respawn,
        output x_rel_pos, y_rel_pos, tank_dir, tank_state, moved
    );
endinterface

// File: rtl/tank_move_ctrl.sv
// Converts held direction buttons into a registered, rate-limited, field-clamped tank pose,
// with an alive/dead state machine driven by hit and respawn pulses.
//
// state    | meaning
// ST_READY | alive, next request is accepted
// ST_COOL  | alive, cooldown running after a move or turn
// ST_DEAD  | destroyed, waiting for respawn
module tank_move_ctrl #(
    parameter int          X_MAX       = 23,
    parameter int          Y_MAX       = 21,
    parameter int          X_INIT      = 11,
    parameter int          Y_INIT      = 21,
    parameter logic [1:0]  DIR_INIT    = 2'b00,
    parameter int          MOVE_PERIOD = 2_500_000,
    parameter int          CNT_W       = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    tank_move_if.slave  io
);

    typedef enum logic [1:0] {
        ST_READY = 2'b00,
        ST_COOL  = 2'b01,
        ST_DEAD  = 2'b10
    } state_t;

    localparam logic [1:0]       DIR_UP     = 2'b00;
    localparam logic [1:0]       DIR_DOWN   = 2'b01;
    localparam logic [1:0]       DIR_LEFT   = 2'b10;
    localparam logic [1:0]       DIR_RIGHT  = 2'b11;
    localparam logic [4:0]       X_MAX_C    = 5'(X_MAX);
    localparam logic [4:0]       Y_MAX_C    = 5'(Y_MAX);
    localparam logic [4:0]       X_INIT_C   = 5'(X_INIT);
    localparam logic [4:0]       Y_INIT_C   = 5'(Y_INIT);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(MOVE_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state_q, state_d;
    logic [4:0]       x_q, x_d;
    logic [4:0]       y_q, y_d;
    logic [1:0]       dir_q, dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             moved_q, moved_d;

    logic             req_valid;
    logic [1:0]       req_dir;
    logic             step_ok;
    logic [4:0]       x_step;
    logic [4:0]       y_step;

    // Fixed priority: up > down > left > right.
    always_comb begin
        req_valid = 1'b1;
        req_dir   = DIR_UP;
        if (io.btn_up) begin
            req_dir = DIR_UP;
        end else if (io.btn_down) begin
            req_dir = DIR_DOWN;
        end else if (io.btn_left) begin
            req_dir = DIR_LEFT;
        end else if (io.btn_right) begin
            req_dir = DIR_RIGHT;
        end else begin
            req_valid = 1'b0;
        end
    end

    // Target cell is bounds-checked before the update so no wrap ever reaches the registers.
    always_comb begin
        step_ok = 1'b0;
        x_step  = x_q;
        y_step  = y_q;
        case (req_dir)
            DIR_UP: begin
                if (y_q != 5'd0) begin
                    step_ok = 1'b1;
                    y_step  = y_q - 5'd1;
                end
            end
            DIR_DOWN: begin
                if (y_q < Y_MAX_C) begin
                    step_ok = 1'b1;
                    y_step  = y_q + 5'd1;
                end
            end
            DIR_LEFT: begin
                if (x_q != 5'd0) begin
                    step_ok = 1'b1;
                    x_step  = x_q - 5'd1;
                end
            end
            default: begin
                if (x_q < X_MAX_C) begin
                    step_ok = 1'b1;
                    x_step  = x_q + 5'd1;
                end
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        moved_d = 1'b0;

        case (state_q)
            ST_READY: begin
                if (io.hit) begin
                    state_d = ST_DEAD;
                end else if (io.enable && req_valid) begin
                    if (dir_q != req_dir) begin
                        dir_d   = req_dir;
                        cnt_d   = CNT_RELOAD;
                        state_d = ST_COOL;
                    end else if (step_ok) begin
                        x_d     = x_step;
                        y_d     = y_step;
                        moved_d = 1'b1;
                        cnt_d   = CNT_RELOAD;
                        state_d = ST_COOL;
                    end
                end
            end
            ST_COOL: begin
                if (io.hit) begin
                    state_d = ST_DEAD;
                end else if (io.enable) begin
                    if (cnt_q == '0) begin
                        state_d = ST_READY;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            ST_DEAD: begin
                // Respawn ignores enable so a paused game can still revive the tank.
                if (io.respawn) begin
                    state_d = ST_READY;
                    x_d     = X_INIT_C;
                    y_d     = Y_INIT_C;
                    dir_d   = DIR_INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_READY;
            x_q     <= X_INIT_C;
            y_q     <= Y_INIT_C;
            dir_q   <= DIR_INIT;
            cnt_q   <= '0;
            moved_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            moved_q <= moved_d;
        end
    end

    assign io.x_rel_pos  = x_q;
    assign io.y_rel_pos  = y_q;
    assign io.tank_dir   = dir_q;
    assign io.tank_state = (state_q != ST_DEAD);
    assign io.moved      = moved_q;

endmodule

// File: tb/tb_tank_move_ctrl.sv
// Scoreboard bench for tank_move_ctrl: stimulus queues expected steps and pose checkpoints,
// a negedge monitor compares them against the DUT.
module tb_tank_move_ctrl;

    localparam int P = 4;

    typedef struct {
        int         cyc;
        logic [4:0] x;
        logic [4:0] y;
        logic [1:0] dir;
        logic       alive;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    int   sq_rd;
    int   cq_rd;
    logic done;
    logic final_checked;

    exp_t sq[$];
    exp_t cq[$];

    logic [4:0] ex_x;
    logic [4:0] ex_y;
    logic [1:0] ex_dir;
    logic       ex_alive;

    tank_move_if tif ();

    tank_move_ctrl #(
        .X_MAX       (23),
        .Y_MAX       (21),
        .X_INIT      (11),
        .Y_INIT      (21),
        .DIR_INIT    (2'b00),
        .MOVE_PERIOD (P),
        .CNT_W       (24)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (tif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares scheduled expectations when their cycle arrives.
    initial begin
        n_cmp = 0;
        n_bad = 0;
        sq_rd = 0;
        cq_rd = 0;
        final_checked = 1'b0;
    end

    always @(negedge clk) begin
        if (tif.moved === 1'b1 || (sq_rd < sq.size() && sq[sq_rd].cyc <= cyc)) begin
            n_cmp++;
            if (sq_rd >= sq.size()) begin
                n_bad++;
                $display("FAIL step_unexpected: got moved=1 at cyc=%0d x=%0d y=%0d, want no move",
                         cyc, tif.x_rel_pos, tif.y_rel_pos);
            end else begin
                if (!(tif.moved === 1'b1 && cyc == sq[sq_rd].cyc && tif.x_rel_pos == sq[sq_rd].x &&
                      tif.y_rel_pos == sq[sq_rd].y && tif.tank_dir == sq[sq_rd].dir)) begin
                    n_bad++;
                    $display("FAIL step: got moved=%0b cyc=%0d x=%0d y=%0d dir=%0d, want moved=1 cyc=%0d x=%0d y=%0d dir=%0d",
                             tif.moved, cyc, tif.x_rel_pos, tif.y_rel_pos, tif.tank_dir,
                             sq[sq_rd].cyc, sq[sq_rd].x, sq[sq_rd].y, sq[sq_rd].dir);
                end
                sq_rd++;
            end
        end
        while (cq_rd < cq.size() && cq[cq_rd].cyc <= cyc) begin
            n_cmp++;
            if (!(cyc == cq[cq_rd].cyc && tif.x_rel_pos == cq[cq_rd].x && tif.y_rel_pos == cq[cq_rd].y &&
                  tif.tank_dir == cq[cq_rd].dir && tif.tank_state == cq[cq_rd].alive)) begin
                n_bad++;
                $display("FAIL pose: got cyc=%0d x=%0d y=%0d dir=%0d alive=%0b, want cyc=%0d x=%0d y=%0d dir=%0d alive=%0b",
                         cyc, tif.x_rel_pos, tif.y_rel_pos, tif.tank_dir, tif.tank_state,
                         cq[cq_rd].cyc, cq[cq_rd].x, cq[cq_rd].y, cq[cq_rd].dir, cq[cq_rd].alive);
            end
            cq_rd++;
        end
        if (done === 1'b1 && !final_checked) begin
            final_checked = 1'b1;
            n_cmp++;
            if (sq_rd != sq.size() || cq_rd != cq.size()) begin
                n_bad++;
                $display("FAIL leftover: got consumed steps=%0d pose=%0d, want steps=%0d pose=%0d",
                         sq_rd, cq_rd, sq.size(), cq.size());
            end
        end
        if (cyc > 4000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL watchdog: got cyc=%0d, want finish before 4000", cyc);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    task automatic push_step(input int c);
        exp_t e;
        e.cyc = c; e.x = ex_x; e.y = ex_y; e.dir = ex_dir; e.alive = ex_alive;
        sq.push_back(e);
    endtask

    task automatic push_chk(input int c);
        exp_t e;
        e.cyc = c; e.x = ex_x; e.y = ex_y; e.dir = ex_dir; e.alive = ex_alive;
        cq.push_back(e);
    endtask

    task automatic set_btn(input logic [3:0] m);
        tif.btn_up    = m[3];
        tif.btn_down  = m[2];
        tif.btn_left  = m[1];
        tif.btn_right = m[0];
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_step(input logic [1:0] d);
        case (d)
            2'd0: ex_y = ex_y - 5'd1;
            2'd1: ex_y = ex_y + 5'd1;
            2'd2: ex_x = ex_x - 5'd1;
            default: ex_x = ex_x + 5'd1;
        endcase
    endtask

    // Held button while already facing d: n steps spaced P+1 cycles apart.
    task automatic step_n(input logic [3:0] m, input logic [1:0] d, input int n);
        int c;
        c = cyc;
        for (int k = 0; k < n; k++) begin
            model_step(d);
            push_step(c + 1 + (P + 1) * k);
        end
        set_btn(m);
        idle((P + 1) * (n - 1) + 1);
        set_btn(4'b0000);
        idle(P + 1);
    endtask

    task automatic turn(input logic [3:0] m, input logic [1:0] d);
        ex_dir = d;
        push_chk(cyc + 1);
        set_btn(m);
        idle(1);
        set_btn(4'b0000);
        idle(P + 1);
    endtask

    task automatic blocked(input logic [3:0] m, input int n);
        set_btn(m);
        idle(n);
        set_btn(4'b0000);
        push_chk(cyc + 1);
        idle(1);
    endtask

    initial begin
        int c;
        done        = 1'b0;
        rst_n       = 1'b0;
        tif.enable  = 1'b1;
        tif.hit     = 1'b0;
        tif.respawn = 1'b0;
        set_btn(4'b0000);
        ex_x = 5'd11; ex_y = 5'd21; ex_dir = 2'd0; ex_alive = 1'b1;
        idle(3);
        rst_n = 1'b1;
        push_chk(cyc + 1);
        idle(2);

        // Held up from reset: y 21 -> 20 -> 19 -> 18.
        step_n(4'b1000, 2'd0, 3);

        // Turn right then keep holding: first step P+1 cycles after the turn.
        c = cyc;
        ex_dir = 2'd3;
        push_chk(c + 1);
        ex_x = 5'd12;
        push_step(c + 1 + P + 1);
        set_btn(4'b0001);
        idle(P + 2);
        set_btn(4'b0000);
        idle(P + 1);

        // Right edge clamp, then an immediate turn proves the state stayed READY.
        step_n(4'b0001, 2'd3, 11);
        blocked(4'b0001, 12);
        turn(4'b1000, 2'd0);
        step_n(4'b1000, 2'd0, 18);
        blocked(4'b1010, 12);

        // Up+left together while facing up: only y moves.
        turn(4'b0100, 2'd1);
        step_n(4'b0100, 2'd1, 2);
        turn(4'b1000, 2'd0);
        step_n(4'b1010, 2'd0, 1);

        // Enable pause of 10 cycles in cooldown delays the next step by 10.
        turn(4'b0010, 2'd2);
        c = cyc;
        ex_x = 5'd22;
        push_step(c + 1);
        ex_x = 5'd21;
        push_step(c + 1 + P + 1 + 10);
        set_btn(4'b0010);
        idle(2);
        tif.enable = 1'b0;
        idle(10);
        tif.enable = 1'b1;
        idle(4);
        set_btn(4'b0000);
        idle(P + 2);

        // Respawn while alive is ignored.
        tif.respawn = 1'b1;
        push_chk(cyc + 1);
        idle(1);
        tif.respawn = 1'b0;
        idle(1);

        // Hit beats a same-cycle legal move; buttons ignored while dead.
        ex_alive = 1'b0;
        push_chk(cyc + 1);
        set_btn(4'b0010);
        tif.hit = 1'b1;
        idle(1);
        tif.hit = 1'b0;
        idle(7);
        push_chk(cyc + 1);
        idle(1);

        // Respawn with up held: init pose, then a step on the very next edge.
        ex_x = 5'd11; ex_y = 5'd21; ex_dir = 2'd0; ex_alive = 1'b1;
        push_chk(cyc + 1);
        ex_y = 5'd20;
        push_step(cyc + 2);
        tif.respawn = 1'b1;
        set_btn(4'b1000);
        idle(1);
        tif.respawn = 1'b0;
        idle(1);
        set_btn(4'b0000);
        idle(1);

        // Reset mid-cooldown, then a step is accepted immediately.
        rst_n = 1'b0;
        ex_y = 5'd21;
        push_chk(cyc + 1);
        idle(1);
        rst_n = 1'b1;
        set_btn(4'b1000);
        ex_y = 5'd20;
        push_step(cyc + 1);
        idle(1);
        set_btn(4'b0000);
        idle(P + 2);

        // Respawn honoured while enable is low.
        ex_alive = 1'b0;
        push_chk(cyc + 1);
        tif.hit = 1'b1;
        idle(1);
        tif.hit = 1'b0;
        tif.enable = 1'b0;
        tif.respawn = 1'b1;
        ex_y = 5'd21; ex_alive = 1'b1;
        push_chk(cyc + 1);
        idle(1);
        tif.respawn = 1'b0;
        tif.enable = 1'b1;
        idle(3);

        done = 1'b1;
        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
